tmds_encoder_dvi: RTL and testbench

Downstream consumer of the display timing generator's sync, blank and pixel outputs. Converts one 8-bit colour channel plus two control bits into a 10-bit DVI 1.0 TMDS symbol per pixel clock. Runs transition minimisation and running DC-balance tracking. Three instances (blue with {vs,hs}, green, red) feed the serialiser.

---
 rtl/tmds_encoder_dvi_if.sv | 22 ++
 rtl/tmds_encoder_dvi.sv | 141 ++++++++++++++
 tb/tb_tmds_encoder_dvi.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tmds_encoder_dvi_if.sv
// Pixel-side bundle for one TMDS channel encoder:
// colour byte, control pair, display enable in; 10-bit symbol out.
interface tmds_encoder_dvi_if;
  logic [7:0] i_data;
  logic [1:0] i_ctrl;
  logic       i_de;
  logic [9:0] o_tmds;

  modport master (
    output i_data,
    output i_ctrl,
    output i_de,
    input  o_tmds
  );

  modport slave (
    input  i_data,
    input  i_ctrl,
    input  i_de,
    output o_tmds
  );
endinterface

// File: rtl/tmds_encoder_dvi.sv
// DVI 1.0 TMDS channel encoder: transition minimise + DC balance.
// Define TMDS_ENC_REG_IN_EN to add an input register stage (latency 3).
module tmds_encoder_dvi (
  input  logic                i_pix_clk,
  input  logic                i_rst,
  tmds_encoder_dvi_if.slave   bus
);

  logic [7:0] s_data;
  logic [1:0] s_ctrl;
  logic       s_de;

`ifdef TMDS_ENC_REG_IN_EN
  logic [7:0] in_data;
  logic [1:0] in_ctrl;
  logic       in_de;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      in_data <= '0;
      in_ctrl <= '0;
      in_de   <= 1'b0;
    end else begin
      in_data <= bus.i_data;
      in_ctrl <= bus.i_ctrl;
      in_de   <= bus.i_de;
    end
  end

  assign s_data = in_data;
  assign s_ctrl = in_ctrl;
  assign s_de   = in_de;
`else
  assign s_data = bus.i_data;
  assign s_ctrl = bus.i_ctrl;
  assign s_de   = bus.i_de;
`endif

  logic [3:0] n1;
  logic       use_xnor;
  logic [8:0] qm_c;

  always_comb begin
    n1 = '0;
    for (int i = 0; i < 8; i++)
      n1 = n1 + {3'b000, s_data[i]};
    use_xnor = (n1 > 4'd4) ||
               ((n1 == 4'd4) && !s_data[0]);
    qm_c = '0;
    qm_c[0] = s_data[0];
    for (int i = 1; i < 8; i++)
      qm_c[i] = use_xnor ?
                ~(qm_c[i-1] ^ s_data[i]) :
                 (qm_c[i-1] ^ s_data[i]);
    qm_c[8] = !use_xnor;
  end

  logic [8:0] qm;
  logic       de1;
  logic [1:0] ctrl1;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      qm    <= '0;
      de1   <= 1'b0;
      ctrl1 <= '0;
    end else begin
      qm    <= qm_c;
      de1   <= s_de;
      ctrl1 <= s_ctrl;
    end
  end

  logic [5:0] bias;
  logic [5:0] bias_nx;
  logic [9:0] tmds_nx;
  logic [3:0] n1q;
  logic [5:0] diff;
  logic [5:0] qm8_x2;
  logic [5:0] nqm8_x2;
  logic       neutral;
  logic       invert;

  always_comb begin
    n1q = '0;
    for (int i = 0; i < 8; i++)
      n1q = n1q + {3'b000, qm[i]};
    // N1q - N0q == 2*N1q - 8
    diff    = {1'b0, n1q, 1'b0} - 6'd8;
    qm8_x2  = {4'b0000, qm[8], 1'b0};
    nqm8_x2 = {4'b0000, ~qm[8], 1'b0};
    neutral = (bias == 6'd0) || (n1q == 4'd4);
    invert  = (!bias[5] && n1q > 4'd4) ||
              ( bias[5] && n1q < 4'd4);
  end

  always_comb begin
    tmds_nx = 10'b1101010100;
    bias_nx = bias;
    unique case (1'b1)
      !de1: begin
        bias_nx = '0;
        unique case (ctrl1)
          2'b00: tmds_nx = 10'b1101010100;
          2'b01: tmds_nx = 10'b0010101011;
          2'b10: tmds_nx = 10'b0101010100;
          2'b11: tmds_nx = 10'b1010101011;
        endcase
      end
      de1 && neutral: begin
        tmds_nx = {~qm[8], qm[8],
                   qm[8] ? qm[7:0] : ~qm[7:0]};
        bias_nx = qm[8] ? bias + diff :
                          bias - diff;
      end
      de1 && !neutral && invert: begin
        tmds_nx = {1'b1, qm[8], ~qm[7:0]};
        bias_nx = bias + qm8_x2 - diff;
      end
      de1 && !neutral && !invert: begin
        tmds_nx = {1'b0, qm[8], qm[7:0]};
        bias_nx = bias - nqm8_x2 + diff;
      end
    endcase
  end

  logic [9:0] tmds_q;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      tmds_q <= 10'b1101010100;
      bias   <= '0;
    end else begin
      tmds_q <= tmds_nx;
      bias   <= bias_nx;
    end
  end

  assign bus.o_tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Scoreboard bench for tmds_encoder_dvi: directed vectors,
// then a short random run against a behavioural encoder.
module tb_tmds_encoder_dvi;

`ifdef TMDS_ENC_REG_IN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  tmds_encoder_dvi_if bus ();

  tmds_encoder_dvi dut (
    .i_pix_clk (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  typedef struct {
    logic [9:0] exp;
    logic       chk;
    logic [7:0] d;
    logic       de;
    string      name;
  } ent_t;

  ent_t q[$];
  int   pass_cnt = 0;
  int   total    = 0;
  int   chk_push = 0;
  int   chk_pop  = 0;
  int   m_bias   = 0;

  function automatic logic [9:0] model_enc(
    logic [7:0] d, logic de, logic [1:0] c);
    int n1, ones, disp;
    logic xn;
    logic [8:0] qm;
    logic [9:0] r;
    if (!de) begin
      m_bias = 0;
      case (c)
        2'b00: r = 10'h354;
        2'b01: r = 10'h0AB;
        2'b10: r = 10'h154;
        default: r = 10'h2AB;
      endcase
      return r;
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    ones = $countones(qm[7:0]);
    disp = ones - (8 - ones);
    if (m_bias == 0 || disp == 0) begin
      r = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      m_bias += qm[8] ? disp : -disp;
    end else if ((m_bias > 0 && disp > 0) ||
                 (m_bias < 0 && disp < 0)) begin
      r = {1'b1, qm[8], ~qm[7:0]};
      m_bias += (qm[8] ? 2 : 0) - disp;
    end else begin
      r = {1'b0, qm[8], qm[7:0]};
      m_bias += (qm[8] ? 0 : -2) + disp;
    end
    return r;
  endfunction

  function automatic logic [7:0] decode(logic [9:0] s);
    logic [7:0] b;
    logic [7:0] d;
    b = s[9] ? ~s[7:0] : s[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    return d;
  endfunction

  task automatic drive(input logic r, input logic [7:0] d,
                       input logic de, input logic [1:0] c,
                       input logic chk, input logic [9:0] exp,
                       input string name);
    ent_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.i_data = d;
    bus.i_de   = de;
    bus.i_ctrl = c;
    e.exp  = exp;
    e.chk  = chk;
    e.d    = d;
    e.de   = de && !r;
    e.name = name;
    q.push_back(e);
    if (chk) chk_push++;
  endtask

  always @(negedge clk) begin
    if (q.size() > LAT) begin
      ent_t e;
      e = q.pop_front();
      if (e.chk) begin
        chk_pop++;
        total++;
        if (bus.o_tmds === e.exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h",
                      e.name, bus.o_tmds, e.exp);
        if (e.de) begin
          total++;
          if (decode(bus.o_tmds) === e.d) pass_cnt++;
          else $display("FAIL %s_decode: got %h want %h",
                        e.name, decode(bus.o_tmds), e.d);
        end
      end
    end
  end

  logic [9:0] zero_seq [6];
  logic [9:0] ctl_seq  [4];

  initial begin
    logic [7:0] rd;
    logic       rde;
    logic [1:0] rc;
    zero_seq = '{10'h100, 10'h3FF, 10'h100,
                 10'h3FF, 10'h100, 10'h3FF};
    ctl_seq  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    bus.i_data = '0;
    bus.i_de   = 1'b0;
    bus.i_ctrl = '0;

    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'($urandom), 1'($urandom), 2'($urandom),
            1'b1, 10'h354, "reset");
    for (int i = 0; i < 2; i++)
      drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 10'h354, "post_reset");

    for (int i = 0; i < 4; i++)
      drive(1'b0, 8'hA5, 1'b0, 2'(i), 1'b1, ctl_seq[i], "ctrl_token");

    for (int i = 0; i < 6; i++)
      drive(1'b0, 8'h00, 1'b1, 2'b11, 1'b1, zero_seq[i], "zero_data");

    drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 10'h354, "blank_pre_ff");
    drive(1'b0, 8'hFF, 1'b1, 2'b00, 1'b1, 10'h200, "ones_first");
    drive(1'b0, 8'hFF, 1'b1, 2'b00, 1'b1, 10'h0FF, "ones_second");

    drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 10'h354, "blank_pre_mid");
    for (int i = 0; i < 3; i++)
      drive(1'b0, 8'h00, 1'b1, 2'b00, 1'b1, zero_seq[i], "mid_active");
    drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 10'h354, "mid_blank");
    drive(1'b0, 8'h00, 1'b1, 2'b00, 1'b1, 10'h100, "mid_bias_reset");

    drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 10'h354, "blank_pre_55");
    drive(1'b0, 8'h55, 1'b1, 2'b00, 1'b1, 10'h133, "data55_a");
    drive(1'b0, 8'h55, 1'b1, 2'b00, 1'b1, 10'h133, "data55_b");

    drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b1,
          model_enc(8'h00, 1'b0, 2'b00), "rand_start");
    for (int i = 0; i < 400; i++) begin
      rd  = 8'($urandom);
      rde = ($urandom_range(0, 9) != 0);
      rc  = 2'($urandom);
      drive(1'b0, rd, rde, rc, 1'b1, model_enc(rd, rde, rc), "random");
    end

    for (int i = 0; i < LAT; i++)
      drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 10'h000, "flush");
    for (int i = 0; i < LAT + 2; i++)
      @(posedge clk);

    total++;
    if (chk_pop == chk_push) pass_cnt++;
    else $display("FAIL drain: checked %0d want %0d", chk_pop, chk_push);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
